unpack_sk_stream: RTL and testbench

Streaming secret-key decoder, the inverse of the team's combinational secret-key packer (K=6, L=5, 3-bit eta fields, 13-bit t0 fields, 3648-byte key). Accepts the packed key one byte per handshake, LSB-first, captures the rho/key/tr header into holding registers and emits the s1, s2 and t0 coefficients one per handshake as signed 32-bit values, tagged with field, polynomial and coefficient index. It sits between the key store / byte channel and the signing datapath's polynomial RAMs.

---
 rtl/unpack_sk_stream.sv | 234 +++++++++++++++++++++++
 tb/tb_unpack_sk_stream.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unpack_sk_stream.sv
// Streaming secret-key decoder: takes the packed key one byte per handshake, latches the
// rho/key/tr header and emits s1, s2 and t0 coefficients as tagged signed 32-bit values.
//
// state | meaning
// IDLE  | waiting for start, busy low
// HDR   | 96 header bytes into rho/key/tr
// S1    | s1 eta fields, 3 bits each
// S2    | s2 eta fields, 3 bits each
// T0    | t0 fields, 13 bits each
// DRAIN | all bytes in, emptying buffer and output register
// DONE  | one-cycle done pulse
module unpack_sk_stream #(
    parameter int K   = 6,
    parameter int L   = 5,
    parameter int ETA = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [7:0]   in_byte_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [31:0]  coef_data_o,
    output logic [1:0]   coef_sel_o,
    output logic [2:0]   coef_poly_o,
    output logic [7:0]   coef_idx_o,
    output logic         coef_valid_o,
    input  logic         coef_ready_i,
    output logic [255:0] rho_o,
    output logic [255:0] key_o,
    output logic [255:0] tr_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         eta_err_o
);

    localparam int HDR_BYTES = 96;
    localparam int S1_BYTES  = L * 96;
    localparam int S2_BYTES  = K * 96;
    localparam int T0_BYTES  = K * 416;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_S1,
        ST_S2,
        ST_T0,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t        state_q;
    logic [11:0]   byte_cnt_q;
    logic [23:0]   buf_q;
    logic [4:0]    cnt_q;
    logic [31:0]   coef_data_q;
    logic [1:0]    coef_sel_q;
    logic [2:0]    coef_poly_q;
    logic [7:0]    coef_idx_q;
    logic          coef_valid_q;
    logic [2:0]    nxt_poly_q;
    logic [7:0]    nxt_idx_q;
    logic [255:0]  rho_q;
    logic [255:0]  key_q;
    logic [255:0]  tr_q;
    logic          eta_err_q;

    logic          in_ready;
    logic          accept;
    logic          accept_bits;
    logic          t0_bits;
    logic [4:0]    width;
    logic          out_free;
    logic          extract;
    logic [1:0]    sel_d;
    logic [31:0]   coef_d;
    logic [23:0]   shifted;
    logic [4:0]    cnt_sh;
    logic [23:0]   buf_d;
    logic [4:0]    cnt_d;
    logic [6:0]    hdr_pos;

    always_comb begin
        in_ready    = (state_q inside {ST_HDR, ST_S1, ST_S2, ST_T0})
                      && (cnt_q <= 5'd16) && (byte_cnt_q != 12'd0);
        accept      = in_ready && in_valid_i;
        accept_bits = accept && (state_q != ST_HDR);
        t0_bits     = state_q inside {ST_T0, ST_DRAIN};
        width       = t0_bits ? 5'd13 : 5'd3;
        out_free    = !coef_valid_q || coef_ready_i;
        extract     = (state_q inside {ST_S1, ST_S2, ST_T0, ST_DRAIN})
                      && (cnt_q >= width) && out_free;
        sel_d       = t0_bits ? 2'd2 : ((state_q == ST_S2) ? 2'd1 : 2'd0);
        // Unsigned subtraction wraps to the two's-complement result directly.
        if (t0_bits) begin
            coef_d = 32'd4096 - {19'd0, buf_q[12:0]};
        end else begin
            coef_d = 32'(ETA) - {29'd0, buf_q[2:0]};
        end
        shifted = extract ? (buf_q >> width) : buf_q;
        cnt_sh  = extract ? (cnt_q - width) : cnt_q;
        buf_d   = shifted;
        cnt_d   = cnt_sh;
        if (accept_bits) begin
            buf_d = shifted | ({16'd0, in_byte_i} << cnt_sh);
            cnt_d = cnt_sh + 5'd8;
        end
        hdr_pos = 7'(HDR_BYTES - 32'(byte_cnt_q));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= '0;
            buf_q        <= '0;
            cnt_q        <= '0;
            coef_data_q  <= '0;
            coef_sel_q   <= '0;
            coef_poly_q  <= '0;
            coef_idx_q   <= '0;
            coef_valid_q <= 1'b0;
            nxt_poly_q   <= '0;
            nxt_idx_q    <= '0;
            rho_q        <= '0;
            key_q        <= '0;
            tr_q         <= '0;
            eta_err_q    <= 1'b0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;

            if (accept) begin
                byte_cnt_q <= byte_cnt_q - 12'd1;
            end

            if (accept && state_q == ST_HDR) begin
                if (hdr_pos < 7'd32) begin
                    rho_q[{hdr_pos[4:0], 3'd0} +: 8] <= in_byte_i;
                end else if (hdr_pos < 7'd64) begin
                    key_q[{hdr_pos[4:0], 3'd0} +: 8] <= in_byte_i;
                end else begin
                    tr_q[{hdr_pos[4:0], 3'd0} +: 8] <= in_byte_i;
                end
            end

            if (extract) begin
                coef_valid_q <= 1'b1;
                coef_data_q  <= coef_d;
                coef_sel_q   <= sel_d;
                coef_poly_q  <= nxt_poly_q;
                coef_idx_q   <= nxt_idx_q;
                nxt_idx_q    <= nxt_idx_q + 8'd1;
                if (nxt_idx_q == 8'd255) begin
                    nxt_poly_q <= nxt_poly_q + 3'd1;
                end
                if (!t0_bits && buf_q[2:0] > 3'(2 * ETA)) begin
                    eta_err_q <= 1'b1;
                end
            end else if (coef_ready_i) begin
                coef_valid_q <= 1'b0;
            end

            // Field changes only happen with an empty buffer, so no extract collides with the index reset.
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q    <= ST_HDR;
                        byte_cnt_q <= 12'(HDR_BYTES);
                        buf_q      <= '0;
                        cnt_q      <= '0;
                        nxt_poly_q <= '0;
                        nxt_idx_q  <= '0;
                        rho_q      <= '0;
                        key_q      <= '0;
                        tr_q       <= '0;
                        eta_err_q  <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (byte_cnt_q == 12'd0) begin
                        state_q    <= ST_S1;
                        byte_cnt_q <= 12'(S1_BYTES);
                    end
                end
                ST_S1: begin
                    if (byte_cnt_q == 12'd0 && cnt_q == 5'd0) begin
                        state_q    <= ST_S2;
                        byte_cnt_q <= 12'(S2_BYTES);
                        nxt_poly_q <= '0;
                        nxt_idx_q  <= '0;
                    end
                end
                ST_S2: begin
                    if (byte_cnt_q == 12'd0 && cnt_q == 5'd0) begin
                        state_q    <= ST_T0;
                        byte_cnt_q <= 12'(T0_BYTES);
                        nxt_poly_q <= '0;
                        nxt_idx_q  <= '0;
                    end
                end
                ST_T0: begin
                    if (byte_cnt_q == 12'd0) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == 5'd0 && out_free) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o   = in_ready;
    assign coef_data_o  = coef_data_q;
    assign coef_sel_o   = coef_sel_q;
    assign coef_poly_o  = coef_poly_q;
    assign coef_idx_o   = coef_idx_q;
    assign coef_valid_o = coef_valid_q;
    assign rho_o        = rho_q;
    assign key_o        = key_q;
    assign tr_o         = tr_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign eta_err_o    = eta_err_q;

endmodule

// File: tb/tb_unpack_sk_stream.sv
// Bench for unpack_sk_stream: whole keys streamed in with random stalls, outputs compared
// against a bit-position reference unpack, plus a table of directed field decodes.
module tb_unpack_sk_stream;

    localparam int NB   = 3648;
    localparam int NEXP = 4352;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [7:0]   in_byte_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [31:0]  coef_data_o;
    logic [1:0]   coef_sel_o;
    logic [2:0]   coef_poly_o;
    logic [7:0]   coef_idx_o;
    logic         coef_valid_o;
    logic         coef_ready_i;
    logic [255:0] rho_o, key_o, tr_o;
    logic         busy_o, done_o, eta_err_o;

    always #5 clk_i = ~clk_i;

    unpack_sk_stream #(.K(6), .L(5), .ETA(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .in_byte_i(in_byte_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .coef_data_o(coef_data_o), .coef_sel_o(coef_sel_o), .coef_poly_o(coef_poly_o),
        .coef_idx_o(coef_idx_o), .coef_valid_o(coef_valid_o), .coef_ready_i(coef_ready_i),
        .rho_o(rho_o), .key_o(key_o), .tr_o(tr_o),
        .busy_o(busy_o), .done_o(done_o), .eta_err_o(eta_err_o)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] key_mem [NB];

    typedef struct {
        int          sel;
        int          poly;
        int          idx;
        logic [31:0] data;
    } coef_t;

    coef_t        exp_arr [NEXP];
    int           n_exp;
    logic         exp_eta_err;
    logic [255:0] exp_rho, exp_key, exp_tr;
    logic [31:0]  cap [3][1536];
    int           last_sel, last_poly, last_idx;

    typedef struct {
        int          sel;
        int          pos;
        int          fval;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic int base_of(input int sel);
        return (sel == 0) ? 768 : ((sel == 1) ? 4608 : 9216);
    endfunction

    function automatic int width_of(input int sel);
        return (sel == 2) ? 13 : 3;
    endfunction

    function automatic int count_of(input int sel);
        return (sel == 0) ? 1280 : 1536;
    endfunction

    function automatic int get_field(input int bp, input int w);
        int v = 0;
        for (int k = 0; k < w; k++) begin
            if (key_mem[(bp + k) / 8][(bp + k) % 8]) v = v | (1 << k);
        end
        return v;
    endfunction

    task automatic set_field(input int bp, input int w, input int val);
        for (int k = 0; k < w; k++) begin
            key_mem[(bp + k) / 8][(bp + k) % 8] = val[k];
        end
    endtask

    task automatic clear_key();
        for (int i = 0; i < NB; i++) key_mem[i] = 8'h00;
    endtask

    task automatic fill_random(input int eta_max);
        for (int i = 0; i < 96; i++) key_mem[i] = 8'($urandom_range(0, 255));
        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < count_of(s); c++) begin
                set_field(base_of(s) + c * width_of(s), width_of(s),
                          (s == 2) ? int'($urandom_range(0, 8191)) : int'($urandom_range(0, eta_max)));
            end
        end
    endtask

    // Reference unpack straight from bit positions in the packed key.
    task automatic build_model();
        int b;
        n_exp = 0;
        exp_eta_err = 1'b0;
        exp_rho = '0; exp_key = '0; exp_tr = '0;
        for (int j = 0; j < 96; j++) begin
            if (j < 32)      exp_rho[8 * j +: 8] = key_mem[j];
            else if (j < 64) exp_key[8 * (j - 32) +: 8] = key_mem[j];
            else             exp_tr[8 * (j - 64) +: 8] = key_mem[j];
        end
        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < count_of(s); c++) begin
                b = get_field(base_of(s) + c * width_of(s), width_of(s));
                exp_arr[n_exp].sel  = s;
                exp_arr[n_exp].poly = c / 256;
                exp_arr[n_exp].idx  = c % 256;
                exp_arr[n_exp].data = (s == 2) ? 32'(4096 - b) : 32'(2 - b);
                if (s < 2 && b > 4) exp_eta_err = 1'b1;
                n_exp++;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready_o, 0);
        chk({tag, "_coef_valid"}, coef_valid_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_eta_err"}, eta_err_o, 0);
        chk({tag, "_coef_data"}, coef_data_o, 0);
        chk({tag, "_tags"}, {coef_sel_o, coef_poly_o, coef_idx_o}, 0);
        chk({tag, "_rho"}, rho_o, 0);
        chk({tag, "_key"}, key_o, 0);
        chk({tag, "_tr"}, tr_o, 0);
    endtask

    task automatic run_key(input int ready_pct, input int valid_pct,
                           input int abort_at, input int mid_start_at);
        int          bi = 0;
        int          ei = 0;
        bit          seen_done = 0;
        bit          stalled = 0;
        logic [44:0] saved;
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 1536; i++) cap[s][i] = 'x;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("busy_after_start", busy_o, 1);
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (stalled) begin
                chk("stall_valid", coef_valid_o, 1);
                chk("stall_hold", {coef_sel_o, coef_poly_o, coef_idx_o, coef_data_o}, saved);
            end
            if (done_o) begin
                seen_done = 1;
                break;
            end
            if (abort_at >= 0 && bi >= abort_at) begin
                in_valid_i = 1'b0;
                coef_ready_i = 1'b0;
                start_i = 1'b0;
                rst_i = 1'b1;
                #1;
                check_reset("midrst");
                @(negedge clk_i);
                rst_i = 1'b0;
                return;
            end
            coef_ready_i = ($urandom_range(0, 99) < ready_pct);
            if (coef_valid_o && coef_ready_i) begin
                if (ei < n_exp) begin
                    chk($sformatf("coef%0d", ei),
                        {coef_sel_o, coef_poly_o, coef_idx_o, coef_data_o},
                        {2'(exp_arr[ei].sel), 3'(exp_arr[ei].poly), 8'(exp_arr[ei].idx), exp_arr[ei].data});
                end else begin
                    chk("extra_coef", 1, 0);
                end
                if (coef_sel_o < 2'd3 && (int'(coef_poly_o) * 256 + int'(coef_idx_o)) < 1536)
                    cap[coef_sel_o][int'(coef_poly_o) * 256 + int'(coef_idx_o)] = coef_data_o;
                last_sel = coef_sel_o; last_poly = coef_poly_o; last_idx = coef_idx_o;
                ei++;
            end
            stalled = coef_valid_o && !coef_ready_i;
            saved = {coef_sel_o, coef_poly_o, coef_idx_o, coef_data_o};
            if (bi < NB && $urandom_range(0, 99) < valid_pct) begin
                in_valid_i = 1'b1;
                in_byte_i = key_mem[bi];
            end else begin
                in_valid_i = 1'b0;
                in_byte_i = 8'($urandom_range(0, 255));
            end
            start_i = (mid_start_at >= 0 && bi == mid_start_at);
            #1;
            if (in_valid_i && in_ready_o) bi++;
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        start_i = 1'b0;
        if (!seen_done) begin
            chk("done_timeout", 0, 1);
            return;
        end
        chk("coef_count", ei, n_exp);
        chk("bytes_consumed", bi, NB);
        chk("eta_err_at_done", eta_err_o, exp_eta_err);
        chk("rho", rho_o, exp_rho);
        chk("key", key_o, exp_key);
        chk("tr", tr_o, exp_tr);
        chk("last_tags", {2'(last_sel), 3'(last_poly), 8'(last_idx)}, {2'd2, 3'd5, 8'd255});
        @(negedge clk_i);
        chk("done_one_cycle", done_o, 0);
        chk("idle_after_done", busy_o, 0);
        chk("eta_err_sticky", eta_err_o, exp_eta_err);
        chk("no_valid_after_done", coef_valid_o, 0);
    endtask

    initial begin
        vecs[0]  = '{0, 0, 4, 32'hFFFFFFFE};
        vecs[1]  = '{0, 1, 1, 32'h00000001};
        vecs[2]  = '{0, 2, 1, 32'h00000001};
        vecs[3]  = '{0, 3, 0, 32'h00000002};
        vecs[4]  = '{0, 4, 1, 32'h00000001};
        vecs[5]  = '{0, 5, 2, 32'h00000000};
        vecs[6]  = '{0, 6, 3, 32'hFFFFFFFF};
        vecs[7]  = '{0, 7, 4, 32'hFFFFFFFE};
        vecs[8]  = '{0, 8, 5, 32'hFFFFFFFD};
        vecs[9]  = '{0, 9, 6, 32'hFFFFFFFC};
        vecs[10] = '{0, 10, 7, 32'hFFFFFFFB};
        vecs[11] = '{1, 0, 3, 32'hFFFFFFFF};
        vecs[12] = '{2, 0, 8191, 32'hFFFFF001};
        vecs[13] = '{2, 1, 0, 32'h00001000};
        vecs[14] = '{2, 2, 4096, 32'h00000000};
        vecs[15] = '{2, 1535, 100, 32'h00000F9C};

        rst_i = 1'b1;
        start_i = 1'b1;
        in_valid_i = 1'b0;
        in_byte_i = 8'h00;
        coef_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_reset("por");
        rst_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk_i);
        chk("rst_beats_start", busy_o, 0);

        // All-zero key.
        clear_key();
        build_model();
        run_key(100, 100, -1, -1);

        // Directed key: counting header, table fields.
        clear_key();
        for (int j = 0; j < 96; j++) key_mem[j] = 8'(j);
        for (int i = 0; i < 16; i++)
            set_field(base_of(vecs[i].sel) + vecs[i].pos * width_of(vecs[i].sel),
                      width_of(vecs[i].sel), vecs[i].fval);
        chk("s1_byte0_pattern", key_mem[96], 8'h4C);
        build_model();
        run_key(100, 100, -1, -1);
        for (int i = 0; i < 16; i++)
            chk($sformatf("vec%0d", i), cap[vecs[i].sel][vecs[i].pos], vecs[i].exp_data);
        chk("rho_byte0", rho_o[7:0], 8'h00);
        chk("key_byte0", key_o[7:0], 8'h20);
        chk("tr_byte31", tr_o[255:248], 8'h5F);
        chk("eta_err_directed", eta_err_o, 1);

        // Random valid key with 50% output stall.
        fill_random(4);
        build_model();
        run_key(50, 100, -1, -1);

        // Key with an early eta error, reset mid-key, then a fresh key with a stray start.
        fill_random(4);
        set_field(768, 3, 7);
        build_model();
        run_key(60, 90, 1000, -1);
        @(negedge clk_i);
        chk("idle_after_midrst", busy_o, 0);
        fill_random(7);
        build_model();
        run_key(70, 80, -1, 500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
